// File: rtl/core_pkg.sv
// Shared encodings for the core pipeline: forward-select codes and default register index width.
package core_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    // E-stage operand select
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // D-stage branch operand select
    localparam logic [1:0] BFWD_RF = 2'b00;
    localparam logic [1:0] BFWD_E  = 2'b01;
    localparam logic [1:0] BFWD_M  = 2'b10;
    localparam logic [1:0] BFWD_W  = 2'b11;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write bit vector for long-latency MDU results, plus the in-flight occupancy counter.
module reg_scoreboard import core_pkg::*; #(
    parameter int unsigned REG_AW    = REG_AW_DEF,
    parameter int unsigned MDU_DEPTH = 2,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue,
    input  logic                   set_en,
    input  logic [REG_AW-1:0]      set_idx,
    input  logic                   clr_en,
    input  logic [REG_AW-1:0]      clr_idx,
    output logic [2**REG_AW-1:0]   sb,
    output logic [CNT_W-1:0]       cnt
);

    logic [2**REG_AW-1:0] sb_d, sb_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;

    // Clear first so a same-index set in the same cycle wins.
    always_comb begin
        sb_d = sb_q;
        if (clr_en) sb_d[clr_idx] = 1'b0;
        if (set_en) sb_d[set_idx] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({issue, clr_en})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    assign sb  = sb_q;
    assign cnt = cnt_q;

    a_done_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(clr_en && cnt_q == '0));
    a_issue_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue && !clr_en && cnt_q == CNT_W'(MDU_DEPTH)));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: operand/branch forwarding, load and branch stalls, and MDU scoreboard stalls.
module hazard_scoreboard_unit import core_pkg::*; #(
    parameter int unsigned REG_AW    = REG_AW_DEF,
    parameter int unsigned MDU_DEPTH = 2,
    parameter int unsigned CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic [REG_AW-1:0] rd_D,
    input  logic              mdu_op_D,
    input  logic              branch_D,
    input  logic [REG_AW-1:0] rs1_E,
    input  logic [REG_AW-1:0] rs2_E,
    input  logic [REG_AW-1:0] rd_E,
    input  logic              regwrite_E,
    input  logic              memtoreg_E,
    input  logic              mdu_op_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic              regwrite_M,
    input  logic              memtoreg_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              regwrite_W,
    input  logic              mdu_done,
    input  logic [REG_AW-1:0] mdu_rd,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [1:0]        BranchForwardAE,
    output logic [1:0]        BranchForwardBE,
    output logic              mdu_busy
);

    logic [2**REG_AW-1:0] sb;
    logic [CNT_W-1:0]     cnt;

    reg_scoreboard #(
        .REG_AW    (REG_AW),
        .MDU_DEPTH (MDU_DEPTH),
        .CNT_W     (CNT_W)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .issue   (mdu_op_E),
        .set_en  (mdu_op_E && rd_E != '0),
        .set_idx (rd_E),
        .clr_en  (mdu_done),
        .clr_idx (mdu_rd),
        .sb      (sb),
        .cnt     (cnt)
    );

    logic e_nz, m_nz, w_nz;
    logic e_src_hit, m_src_hit;
    logic m_fwd_ok, w_fwd_ok, e_bfwd_ok, m_bfwd_ok;
    logic load_use, load_branch, branch_alu, mdu_raw, mdu_waw, mdu_in_e, mdu_full;
    logic [CNT_W:0] occ;

    assign e_nz      = rd_E != '0;
    assign m_nz      = rd_M != '0;
    assign w_nz      = rd_W != '0;
    assign e_src_hit = rd_E == rs1_D || rd_E == rs2_D;
    assign m_src_hit = rd_M == rs1_D || rd_M == rs2_D;

    assign m_fwd_ok  = regwrite_M && !memtoreg_M && m_nz;
    assign w_fwd_ok  = regwrite_W && w_nz;
    assign e_bfwd_ok = regwrite_E && !memtoreg_E && !mdu_op_E && e_nz;
    assign m_bfwd_ok = m_fwd_ok;

    // Occupancy counts the op currently in E, which is not yet in cnt.
    assign occ = {1'b0, cnt} + (CNT_W + 1)'(mdu_op_E);

    assign load_use    = memtoreg_E && e_nz && e_src_hit;
    assign load_branch = branch_D && memtoreg_M && m_nz && m_src_hit;
    assign branch_alu  = branch_D && regwrite_E && !memtoreg_E && e_nz && e_src_hit;
    assign mdu_raw     = sb[rs1_D] || sb[rs2_D];
    assign mdu_waw     = sb[rd_D];
    assign mdu_in_e    = mdu_op_E && e_nz && (e_src_hit || rd_E == rd_D);
    assign mdu_full    = mdu_op_D && occ >= (CNT_W + 1)'(MDU_DEPTH);

    always_comb begin
        StallF = load_use || load_branch || branch_alu || mdu_raw || mdu_waw || mdu_in_e
              || mdu_full;
        StallD = StallF;
        FlushE = StallF;
    end

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (m_fwd_ok && rd_M == rs1_E)      ForwardAE = FWD_M;
        else if (w_fwd_ok && rd_W == rs1_E) ForwardAE = FWD_W;
        if (m_fwd_ok && rd_M == rs2_E)      ForwardBE = FWD_M;
        else if (w_fwd_ok && rd_W == rs2_E) ForwardBE = FWD_W;
    end

    always_comb begin
        BranchForwardAE = BFWD_RF;
        BranchForwardBE = BFWD_RF;
        if (e_bfwd_ok && rd_E == rs1_D)      BranchForwardAE = BFWD_E;
        else if (m_bfwd_ok && rd_M == rs1_D) BranchForwardAE = BFWD_M;
        else if (w_fwd_ok && rd_W == rs1_D)  BranchForwardAE = BFWD_W;
        if (e_bfwd_ok && rd_E == rs2_D)      BranchForwardBE = BFWD_E;
        else if (m_bfwd_ok && rd_M == rs2_D) BranchForwardBE = BFWD_M;
        else if (w_fwd_ok && rd_W == rs2_D)  BranchForwardBE = BFWD_W;
    end

    assign mdu_busy = cnt != '0;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed-vector bench for hazard_scoreboard_unit with hand-computed expectations.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W, mdu_rd;
    logic       mdu_op_D, branch_D, regwrite_E, memtoreg_E, mdu_op_E;
    logic       regwrite_M, memtoreg_M, regwrite_W, mdu_done;
    logic       StallF, StallD, FlushE, mdu_busy;
    logic [1:0] ForwardAE, ForwardBE, BranchForwardAE, BranchForwardBE;
    logic [2:0] stall;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_D           (rs1_D),
        .rs2_D           (rs2_D),
        .rd_D            (rd_D),
        .mdu_op_D        (mdu_op_D),
        .branch_D        (branch_D),
        .rs1_E           (rs1_E),
        .rs2_E           (rs2_E),
        .rd_E            (rd_E),
        .regwrite_E      (regwrite_E),
        .memtoreg_E      (memtoreg_E),
        .mdu_op_E        (mdu_op_E),
        .rd_M            (rd_M),
        .regwrite_M      (regwrite_M),
        .memtoreg_M      (memtoreg_M),
        .rd_W            (rd_W),
        .regwrite_W      (regwrite_W),
        .mdu_done        (mdu_done),
        .mdu_rd          (mdu_rd),
        .StallF          (StallF),
        .StallD          (StallD),
        .FlushE          (FlushE),
        .ForwardAE       (ForwardAE),
        .ForwardBE       (ForwardBE),
        .BranchForwardAE (BranchForwardAE),
        .BranchForwardBE (BranchForwardBE),
        .mdu_busy        (mdu_busy)
    );

    always #5 clk = ~clk;
    assign stall = {StallF, StallD, FlushE};

    task automatic clear_inputs();
        {rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W, mdu_rd} = '0;
        {mdu_op_D, branch_D, regwrite_E, memtoreg_E, mdu_op_E} = '0;
        {regwrite_M, memtoreg_M, regwrite_W, mdu_done} = '0;
    endtask

    // Inputs change 2 time units after the edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        checks++;
        if ({stall, ForwardAE, ForwardBE, BranchForwardAE, BranchForwardBE, mdu_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b fa=%b fb=%b bfa=%b bfb=%b busy=%b want all 0",
                     stall, ForwardAE, ForwardBE, BranchForwardAE, BranchForwardBE, mdu_busy);
        end
        rst_n = 1'b1;
        step();
        // issue MDU op to x5, then reset mid-cycle
        mdu_op_E = 1'b1; rd_E = 5'd5;
        step();
        clear_inputs();
        rs1_D = 5'd5;
        #1;
        checks++;
        if (stall !== 3'b111 || mdu_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_sb5: got stall=%b busy=%b want 111/1", stall, mdu_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 3'b000 || mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got stall=%b busy=%b want 000/0", stall, mdu_busy);
        end
        #1;
        rst_n = 1'b1;
        clear_inputs();
        step();
    endtask

    task automatic test_load_use();
        // lw x3 in E, add x4,x3,x1 in D
        memtoreg_E = 1'b1; regwrite_E = 1'b1; rd_E = 5'd3;
        rs1_D = 5'd3; rs2_D = 5'd1; rd_D = 5'd4;
        #1;
        checks++;
        if (stall !== 3'b111) begin
            errors++;
            $display("FAIL load_use_stall: got %b want 111", stall);
        end
        step();
        // lw in M, bubble in E, add still in D
        clear_inputs();
        memtoreg_M = 1'b1; regwrite_M = 1'b1; rd_M = 5'd3;
        rs1_D = 5'd3; rs2_D = 5'd1; rd_D = 5'd4;
        #1;
        checks++;
        if (stall !== 3'b000) begin
            errors++;
            $display("FAIL load_use_release: got %b want 000", stall);
        end
        // loaded value cannot come from M
        rs1_E = 5'd3;
        #1;
        checks++;
        if (ForwardAE !== 2'b00) begin
            errors++;
            $display("FAIL no_fwd_from_load_M: got %b want 00", ForwardAE);
        end
        step();
        // add in E, lw in W
        clear_inputs();
        rs1_E = 5'd3; rs2_E = 5'd1; regwrite_W = 1'b1; rd_W = 5'd3;
        #1;
        checks++;
        if (ForwardAE !== 2'b01 || ForwardBE !== 2'b00) begin
            errors++;
            $display("FAIL fwd_W: got A=%b B=%b want 01/00", ForwardAE, ForwardBE);
        end
        // M wins over W; x0 never forwarded
        regwrite_M = 1'b1; rd_M = 5'd3; rs2_E = 5'd0; rd_W = 5'd0;
        #1;
        checks++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b00) begin
            errors++;
            $display("FAIL fwd_M_prio: got A=%b B=%b want 10/00", ForwardAE, ForwardBE);
        end
        rd_M = 5'd0; rs1_E = 5'd0; rs2_E = 5'd3; regwrite_W = 1'b1; rd_W = 5'd3;
        #1;
        checks++;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b01) begin
            errors++;
            $display("FAIL fwd_B_W_x0M: got A=%b B=%b want 00/01", ForwardAE, ForwardBE);
        end
        // load to x0 is no hazard
        clear_inputs();
        memtoreg_E = 1'b1; regwrite_E = 1'b1; rd_E = 5'd0;
        #1;
        checks++;
        if (stall !== 3'b000) begin
            errors++;
            $display("FAIL load_x0_nostall: got %b want 000", stall);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_mdu_raw();
        // div x7 in E, add x8,x7,x2 in D
        mdu_op_E = 1'b1; rd_E = 5'd7;
        rs1_D = 5'd7; rs2_D = 5'd2; rd_D = 5'd8;
        #1;
        checks++;
        if (stall !== 3'b111) begin
            errors++;
            $display("FAIL mdu_in_E: got %b want 111", stall);
        end
        step();
        mdu_op_E = 1'b0; rd_E = 5'd0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 20) begin
                mdu_done = 1'b1; mdu_rd = 5'd7;
            end
            #1;
            checks++;
            if (stall !== 3'b111 || mdu_busy !== 1'b1) begin
                errors++;
                $display("FAIL mdu_raw_hold[%0d]: got stall=%b busy=%b want 111/1",
                         i, stall, mdu_busy);
            end
            step();
        end
        mdu_done = 1'b0; mdu_rd = 5'd0;
        #1;
        checks++;
        if (stall !== 3'b000 || mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL mdu_raw_release: got stall=%b busy=%b want 000/0", stall, mdu_busy);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_same_cycle();
        mdu_op_E = 1'b1; rd_E = 5'd9;
        step();
        // re-issue to x9 while the earlier x9 completes
        mdu_done = 1'b1; mdu_rd = 5'd9;
        step();
        clear_inputs();
        rd_D = 5'd9;
        #1;
        checks++;
        if (stall !== 3'b111 || mdu_busy !== 1'b1) begin
            errors++;
            $display("FAIL set_wins_waw: got stall=%b busy=%b want 111/1", stall, mdu_busy);
        end
        mdu_done = 1'b1; mdu_rd = 5'd9;
        step();
        clear_inputs();
        rd_D = 5'd9;
        #1;
        checks++;
        if (stall !== 3'b000 || mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_drain: got stall=%b busy=%b want 000/0", stall, mdu_busy);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_structural();
        mdu_op_E = 1'b1; rd_E = 5'd10;
        step();
        // mul x11 in E (cnt=1), mul x12 in D
        rd_E = 5'd11;
        mdu_op_D = 1'b1; rd_D = 5'd12; rs1_D = 5'd1; rs2_D = 5'd2;
        #1;
        checks++;
        if (stall !== 3'b111) begin
            errors++;
            $display("FAIL struct_cnt1_plusE: got %b want 111", stall);
        end
        step();
        mdu_op_E = 1'b0; rd_E = 5'd0;
        #1;
        checks++;
        if (stall !== 3'b111) begin
            errors++;
            $display("FAIL struct_full: got %b want 111", stall);
        end
        step();
        mdu_done = 1'b1; mdu_rd = 5'd10;
        #1;
        checks++;
        if (stall !== 3'b111) begin
            errors++;
            $display("FAIL struct_done_cycle: got %b want 111", stall);
        end
        step();
        mdu_done = 1'b0; mdu_rd = 5'd0;
        #1;
        checks++;
        if (stall !== 3'b000) begin
            errors++;
            $display("FAIL struct_release: got %b want 000", stall);
        end
        step();
        // mul x12 in E while x11 completes; mul x13 in D must still stall
        mdu_op_E = 1'b1; rd_E = 5'd12; mdu_done = 1'b1; mdu_rd = 5'd11;
        rd_D = 5'd13;
        #1;
        checks++;
        if (stall !== 3'b111) begin
            errors++;
            $display("FAIL struct_fourth_op: got %b want 111", stall);
        end
        step();
        mdu_op_E = 1'b0; rd_E = 5'd0; mdu_done = 1'b1; mdu_rd = 5'd12;
        step();
        clear_inputs();
        #1;
        checks++;
        if (mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL struct_drain: got busy=%b want 0", mdu_busy);
        end
        step();
    endtask

    task automatic test_branch_fwd();
        // beq x5,x6: x5 from ALU op in M, x6 from W
        branch_D = 1'b1; rs1_D = 5'd5; rs2_D = 5'd6;
        regwrite_M = 1'b1; rd_M = 5'd5; regwrite_W = 1'b1; rd_W = 5'd6;
        #1;
        checks++;
        if (BranchForwardAE !== 2'b10 || BranchForwardBE !== 2'b11 || stall !== 3'b000) begin
            errors++;
            $display("FAIL branch_fwd_MW: got A=%b B=%b stall=%b want 10/11/000",
                     BranchForwardAE, BranchForwardBE, stall);
        end
        regwrite_E = 1'b1; rd_E = 5'd5;
        #1;
        checks++;
        if (BranchForwardAE !== 2'b01 || stall !== 3'b111) begin
            errors++;
            $display("FAIL branch_on_E: got A=%b stall=%b want 01/111", BranchForwardAE, stall);
        end
        // load in M feeding the branch
        regwrite_E = 1'b0; rd_E = 5'd0; memtoreg_M = 1'b1;
        #1;
        checks++;
        if (BranchForwardAE !== 2'b00 || stall !== 3'b111) begin
            errors++;
            $display("FAIL load_branch: got A=%b stall=%b want 00/111", BranchForwardAE, stall);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mdu_raw();
        test_same_cycle();
        test_structural();
        test_branch_fwd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
